// File: rtl/add8_seq_ctrl.sv
// add8_seq_ctrl: 8/16/24/32-bit unsigned adder that reuses one 8-bit adder, one byte per cycle.
// Optional feature: define ADD_SEQ_OVF_EN to add the signed-overflow output ovf.
module add8_seq_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  mode,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [32:0] sum
`ifdef ADD_SEQ_OVF_EN
   ,
   output logic        ovf
`endif
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

   state_t      state_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [1:0]  mode_q;
   logic [1:0]  idx_q;
   logic        carry_q;
   logic        out_valid_q;
   logic [32:0] sum_q;
   logic [32:0] sum_d;
   logic [7:0]  a_byte_d;
   logic [7:0]  b_byte_d;
   logic [8:0]  step_d;
   logic        last_d;
   logic [4:0]  op_pos_d;
   logic [5:0]  res_pos_d;
`ifdef ADD_SEQ_OVF_EN
   logic        ovf_q;
   logic        ovf_d;
`endif

   // Shared byte adder: the step index selects both operand bytes and the result slot.
   always_comb begin
      op_pos_d  = {idx_q, 3'b000};
      res_pos_d = {1'b0, idx_q, 3'b000};
      a_byte_d  = a_q[op_pos_d +: 8];
      b_byte_d  = b_q[op_pos_d +: 8];
      step_d    = {1'b0, a_byte_d} + {1'b0, b_byte_d} + {8'd0, carry_q};
      last_d    = (idx_q == mode_q);
      sum_d     = sum_q;
      sum_d[res_pos_d +: 8] = step_d[7:0];
      if (last_d) begin
         sum_d[res_pos_d + 6'd8] = step_d[8];
      end
   end

`ifdef ADD_SEQ_OVF_EN
   always_comb begin
      ovf_d = (a_byte_d[7] == b_byte_d[7]) && (step_d[7] != a_byte_d[7]);
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         mode_q      <= '0;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
`ifdef ADD_SEQ_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b;
                  mode_q  <= mode;
                  idx_q   <= '0;
                  carry_q <= 1'b0;
                  sum_q   <= '0;
`ifdef ADD_SEQ_OVF_EN
                  ovf_q   <= 1'b0;
`endif
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               sum_q   <= sum_d;
               carry_q <= step_d[8];
               idx_q   <= idx_q + 2'd1;
               if (last_d) begin
                  idx_q   <= '0;
`ifdef ADD_SEQ_OVF_EN
                  ovf_q   <= ovf_d;
`endif
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               // out_valid is registered one edge after DONE entry; the handshake needs it asserted.
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
               end else if (out_ready) begin
                  out_valid_q <= 1'b0;
`ifdef ADD_SEQ_OVF_EN
                  ovf_q       <= 1'b0;
`endif
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state_q == S_IDLE) && !rst;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
`ifdef ADD_SEQ_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule
